// File: rtl/qu_instr_decode.sv
// RV32I decode stage with a registered 2-entry output skid buffer.
// Define QU_DECODE_STATS_EN to add the stat_decoded/stat_illegal counters.
module qu_instr_decode #(
    parameter int QU_INSTR_WIDTH = 32,
    parameter int QU_PC_WIDTH    = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [QU_INSTR_WIDTH-1:0] in_instr,
    input  logic [QU_PC_WIDTH-1:0]    in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QU_PC_WIDTH-1:0]    out_pc,
    output logic [2:0]                out_optype,
    output logic [2:0]                out_funct3,
    output logic [6:0]                out_funct7,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic                      out_rd_valid,
    output logic                      out_rs1_valid,
    output logic                      out_rs2_valid,
    output logic                      out_imm_valid,
    output logic [31:0]               out_imm,
    output logic                      out_illegal
`ifdef QU_DECODE_STATS_EN
    ,
    output logic [31:0]               stat_decoded,
    output logic [31:0]               stat_illegal
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] OT_ALU    = 3'd0;
    localparam logic [2:0] OT_LOAD   = 3'd1;
    localparam logic [2:0] OT_STORE  = 3'd2;
    localparam logic [2:0] OT_BRANCH = 3'd3;
    localparam logic [2:0] OT_JUMP   = 3'd4;
    localparam logic [2:0] OT_UPPER  = 3'd5;
    localparam logic [2:0] OT_SYSTEM = 3'd6;
    localparam logic [2:0] OT_ILL    = 3'd7;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [QU_PC_WIDTH-1:0] pc;
        logic [2:0]             optype;
        logic [2:0]             funct3;
        logic [6:0]             funct7;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic                   rd_v;
        logic                   rs1_v;
        logic                   rs2_v;
        logic                   imm_v;
        logic [31:0]            imm;
        logic                   illegal;
    } dec_t;

    dec_t dec_d;
    dec_t main_q;
    dec_t skid_q;
    logic main_v_q;
    logic skid_v_q;
    logic ill;
    logic uimm;
    logic push;
    logic pop;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};

    always_comb begin
        dec_d        = '0;
        ill          = 1'b0;
        uimm         = 1'b0;
        dec_d.pc     = in_pc;
        dec_d.funct3 = f3;
        case (opc)
            OP_R: begin
                dec_d.optype = OT_ALU;
                dec_d.rd_v   = 1'b1;
                dec_d.rs1_v  = 1'b1;
                dec_d.rs2_v  = 1'b1;
                dec_d.funct7 = f7;
                ill = (f7 != F7_ZERO) &&
                      !(f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_I: begin
                dec_d.optype = OT_ALU;
                dec_d.rd_v   = 1'b1;
                dec_d.rs1_v  = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_i;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_d.funct7 = f7;
                    dec_d.imm    = {27'b0, in_instr[24:20]};
                    ill = (f7 != F7_ZERO) &&
                          !(f3 == 3'b101 && f7 == F7_ALT);
                end
            end
            OP_LOAD: begin
                dec_d.optype = OT_LOAD;
                dec_d.rd_v   = 1'b1;
                dec_d.rs1_v  = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_i;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec_d.optype = OT_STORE;
                dec_d.rs1_v  = 1'b1;
                dec_d.rs2_v  = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_s;
                ill = f3[2] || (f3[1] && f3[0]);
            end
            OP_BRANCH: begin
                dec_d.optype = OT_BRANCH;
                dec_d.rs1_v  = 1'b1;
                dec_d.rs2_v  = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_b;
                ill = (f3[2:1] == 2'b01);
            end
            OP_JAL: begin
                dec_d.optype = OT_JUMP;
                dec_d.rd_v   = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_j;
            end
            OP_JALR: begin
                dec_d.optype = OT_JUMP;
                dec_d.rd_v   = 1'b1;
                dec_d.rs1_v  = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_i;
                ill = (f3 != 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                dec_d.optype = OT_UPPER;
                dec_d.rd_v   = 1'b1;
                dec_d.imm_v  = 1'b1;
                dec_d.imm    = imm_u;
            end
            OP_SYSTEM: begin
                dec_d.optype = OT_SYSTEM;
                dec_d.imm_v  = 1'b1;
                if (f3 == 3'b000) begin
                    // only ECALL (imm 0) and EBREAK (imm 1) are accepted
                    dec_d.imm = {31'b0, in_instr[20]};
                    ill = (in_instr[31:21] != '0) || (in_instr[19:7] != '0);
                end else if (f3 == 3'b100) begin
                    ill = 1'b1;
                end else begin
                    dec_d.rd_v  = 1'b1;
                    dec_d.rs1_v = !f3[2];
                    dec_d.imm   = {20'b0, in_instr[31:20]};
                    uimm        = f3[2];
                end
            end
            OP_FENCE: begin
                dec_d.optype = OT_SYSTEM;
                ill = (f3[2:1] != 2'b00);
            end
            default: ill = 1'b1;
        endcase
        dec_d.rd  = dec_d.rd_v ? in_instr[11:7] : 5'd0;
        dec_d.rs1 = (dec_d.rs1_v || uimm) ? in_instr[19:15] : 5'd0;
        dec_d.rs2 = dec_d.rs2_v ? in_instr[24:20] : 5'd0;
        if (ill) begin
            dec_d         = '0;
            dec_d.pc      = in_pc;
            dec_d.funct3  = f3;
            dec_d.optype  = OT_ILL;
            dec_d.illegal = 1'b1;
        end
    end

    assign in_ready = !skid_v_q;
    assign push     = in_valid && !skid_v_q;
    assign pop      = main_v_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else if (pop) begin
            // skid is never full while push is possible
            if (skid_v_q) begin
                main_q   <= skid_q;
                skid_v_q <= 1'b0;
            end else if (push) begin
                main_q <= dec_d;
            end else begin
                main_v_q <= 1'b0;
            end
        end else if (push) begin
            if (main_v_q) begin
                skid_q   <= dec_d;
                skid_v_q <= 1'b1;
            end else begin
                main_q   <= dec_d;
                main_v_q <= 1'b1;
            end
        end
    end

`ifdef QU_DECODE_STATS_EN
    logic [31:0] stat_dec_q;
    logic [31:0] stat_ill_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_dec_q <= '0;
            stat_ill_q <= '0;
        end else if (!flush && pop) begin
            stat_dec_q <= stat_dec_q + 32'd1;
            if (main_q.illegal) begin
                stat_ill_q <= stat_ill_q + 32'd1;
            end
        end
    end

    assign stat_decoded = stat_dec_q;
    assign stat_illegal = stat_ill_q;
`endif

    assign out_valid     = main_v_q;
    assign out_pc        = main_q.pc;
    assign out_optype    = main_q.optype;
    assign out_funct3    = main_q.funct3;
    assign out_funct7    = main_q.funct7;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_rd_valid  = main_q.rd_v;
    assign out_rs1_valid = main_q.rs1_v;
    assign out_rs2_valid = main_q.rs2_v;
    assign out_imm_valid = main_q.imm_v;
    assign out_imm       = main_q.imm;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_qu_instr_decode.sv
// Randomized bench for qu_instr_decode against a queue-based reference model.
// Stats counters are checked when QU_DECODE_STATS_EN is defined.
module tb_qu_instr_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [11:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pc;
    logic [2:0]  out_optype;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_rd_valid;
    logic        out_rs1_valid;
    logic        out_rs2_valid;
    logic        out_imm_valid;
    logic [31:0] out_imm;
    logic        out_illegal;
`ifdef QU_DECODE_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_illegal;
`endif

    always #5 clk = ~clk;

    qu_instr_decode dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_optype    (out_optype),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd_valid  (out_rd_valid),
        .out_rs1_valid (out_rs1_valid),
        .out_rs2_valid (out_rs2_valid),
        .out_imm_valid (out_imm_valid),
        .out_imm       (out_imm),
        .out_illegal   (out_illegal)
`ifdef QU_DECODE_STATS_EN
        ,
        .stat_decoded  (stat_decoded),
        .stat_illegal  (stat_illegal)
`endif
    );

    typedef struct packed {
        logic [11:0] pc;
        logic [2:0]  optype;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdv;
        logic        rs1v;
        logic        rs2v;
        logic        immv;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_dec;
    logic [31:0] m_ill;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int val, input int bits);
        if ((val >> (bits - 1)) & 1) return 32'(val - (1 << bits));
        return 32'(val);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w,
                                        input logic [11:0] pc);
        exp_t e;
        int   op, f3, f7;
        bit   ok, uimm;
        e = '0;
        e.pc = pc;
        e.f3 = w[14:12];
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ok = 1;
        uimm = 0;
        if (op == 'h33) begin
            e.optype = 0; e.rdv = 1; e.rs1v = 1; e.rs2v = 1;
            e.f7 = w[31:25];
            ok = (f7 == 0) || (f7 == 32 && f3 inside {0, 5});
        end else if (op == 'h13) begin
            e.optype = 0; e.rdv = 1; e.rs1v = 1; e.immv = 1;
            e.imm = sx(int'(w[31:20]), 12);
            if (f3 == 1) begin
                e.f7 = w[31:25]; e.imm = 32'(w[24:20]); ok = (f7 == 0);
            end else if (f3 == 5) begin
                e.f7 = w[31:25]; e.imm = 32'(w[24:20]);
                ok = f7 inside {0, 32};
            end
        end else if (op == 'h03) begin
            e.optype = 1; e.rdv = 1; e.rs1v = 1; e.immv = 1;
            e.imm = sx(int'(w[31:20]), 12);
            ok = f3 inside {0, 1, 2, 4, 5};
        end else if (op == 'h23) begin
            e.optype = 2; e.rs1v = 1; e.rs2v = 1; e.immv = 1;
            e.imm = sx(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
            ok = (f3 <= 2);
        end else if (op == 'h63) begin
            e.optype = 3; e.rs1v = 1; e.rs2v = 1; e.immv = 1;
            e.imm = sx(int'(w[31]) * 4096 + int'(w[7]) * 2048
                       + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
            ok = !(f3 inside {2, 3});
        end else if (op == 'h6F) begin
            e.optype = 4; e.rdv = 1; e.immv = 1;
            e.imm = sx(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096
                       + int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
        end else if (op == 'h67) begin
            e.optype = 4; e.rdv = 1; e.rs1v = 1; e.immv = 1;
            e.imm = sx(int'(w[31:20]), 12);
            ok = (f3 == 0);
        end else if (op == 'h37 || op == 'h17) begin
            e.optype = 5; e.rdv = 1; e.immv = 1;
            e.imm = w & 32'hFFFF_F000;
        end else if (op == 'h73) begin
            e.optype = 6; e.immv = 1;
            if (f3 == 0) begin
                ok = (w == 32'h0000_0073) || (w == 32'h0010_0073);
                e.imm = (w == 32'h0010_0073) ? 32'd1 : 32'd0;
            end else if (f3 == 4) begin
                ok = 0;
            end else begin
                e.rdv = 1; e.rs1v = (f3 < 4); uimm = (f3 > 4);
                e.imm = 32'(w[31:20]);
            end
        end else if (op == 'h0F) begin
            e.optype = 6;
            ok = f3 inside {0, 1};
        end else begin
            ok = 0;
        end
        e.rd  = e.rdv ? w[11:7] : 5'd0;
        e.rs1 = (e.rs1v || uimm) ? w[19:15] : 5'd0;
        e.rs2 = e.rs2v ? w[24:20] : 5'd0;
        if (!ok) begin
            e = '0;
            e.pc = pc;
            e.f3 = w[14:12];
            e.optype = 7;
            e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            9: w[6:0] = 7'h73;
            10: w[6:0] = 7'h0F;
            11: w[1:0] = 2'($urandom_range(0, 2));
            12: w = {11'b0, 1'($urandom_range(0, 1)), 20'h00073};
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic compare();
        exp_t e;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            chk("pc", 64'(out_pc), 64'(e.pc));
            chk("optype", 64'(out_optype), 64'(e.optype));
            chk("funct3", 64'(out_funct3), 64'(e.f3));
            chk("funct7", 64'(out_funct7), 64'(e.f7));
            chk("rd", 64'(out_rd), 64'(e.rd));
            chk("rs1", 64'(out_rs1), 64'(e.rs1));
            chk("rs2", 64'(out_rs2), 64'(e.rs2));
            chk("valids", 64'({out_rd_valid, out_rs1_valid,
                               out_rs2_valid, out_imm_valid}),
                64'({e.rdv, e.rs1v, e.rs2v, e.immv}));
            chk("imm", 64'(out_imm), 64'(e.imm));
            chk("illegal", 64'(out_illegal), 64'(e.ill));
        end
`ifdef QU_DECODE_STATS_EN
        chk("stat_decoded", 64'(stat_decoded), 64'(m_dec));
        chk("stat_illegal", 64'(stat_illegal), 64'(m_ill));
`endif
    endtask

    task automatic step(input logic v, input logic [31:0] w,
                        input logic [11:0] pc, input logic ordy,
                        input logic fl);
        bit m_rdy;
        bit m_ov;
        m_rdy = (q.size() < 2);
        m_ov  = (q.size() != 0);
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            q.delete();
        end else begin
            if (m_ov && ordy) begin
                m_dec = m_dec + 32'd1;
                if (q[0].ill) m_ill = m_ill + 32'd1;
                void'(q.pop_front());
            end
            if (v && m_rdy) q.push_back(ref_decode(w, pc));
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset(input logic v);
        rst_n     = 1'b0;
        in_valid  = v;
        in_instr  = rand_instr();
        in_pc     = 12'h0;
        out_ready = 1'b1;
        flush     = 1'b0;
        q.delete();
        m_dec = '0;
        m_ill = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    initial begin
        m_dec = '0;
        m_ill = '0;
        @(negedge clk);
        do_reset(1'b0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_optype", 64'(out_optype), 64'd0);

        step(1'b1, 32'hFFF1_0093, 12'h004, 1'b1, 1'b0);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_optype", 64'(out_optype), 64'd0);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_rs1", 64'(out_rs1), 64'd2);
        chk("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("addi_rs2v", 64'(out_rs2_valid), 64'd0);

        step(1'b1, 32'h0020_8463, 12'h008, 1'b1, 1'b0);
        chk("beq_optype", 64'(out_optype), 64'd3);
        chk("beq_rs1", 64'(out_rs1), 64'd1);
        chk("beq_rs2", 64'(out_rs2), 64'd2);
        chk("beq_imm", 64'(out_imm), 64'h8);
        step(1'b1, 32'h1234_52B7, 12'h00C, 1'b1, 1'b0);
        chk("lui_valid", 64'(out_valid), 64'd1);
        chk("lui_optype", 64'(out_optype), 64'd5);
        chk("lui_rd", 64'(out_rd), 64'd5);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        step(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);

        step(1'b1, 32'h0031_2223, 12'h010, 1'b0, 1'b0);
        chk("sw_in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 32'hFFF1_0093, 12'h014, 1'b0, 1'b0);
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        chk("sw_optype", 64'(out_optype), 64'd2);
        chk("sw_rs1", 64'(out_rs1), 64'd2);
        chk("sw_rs2", 64'(out_rs2), 64'd3);
        chk("sw_imm", 64'(out_imm), 64'd4);
        step(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        chk("order_optype", 64'(out_optype), 64'd0);
        chk("order_pc", 64'(out_pc), 64'h014);
        step(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);

        do_reset(1'b1);
        step(1'b1, 32'h0000_0000, 12'h020, 1'b1, 1'b0);
        chk("zero_optype", 64'(out_optype), 64'd7);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        chk("zero_imm", 64'(out_imm), 64'd0);
        step(1'b1, 32'h4000_1093, 12'h024, 1'b1, 1'b0);
        chk("slli_optype", 64'(out_optype), 64'd7);
        chk("slli_illegal", 64'(out_illegal), 64'd1);
        step(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
`ifdef QU_DECODE_STATS_EN
        chk("stat_ill_two", 64'(stat_illegal), 64'd2);
`endif

        step(1'b1, 32'h0031_2223, 12'h030, 1'b0, 1'b0);
        step(1'b1, 32'h0020_8463, 12'h034, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'h1234_52B7, 12'h038, 1'b1, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 12'h0, 1'b1, 1'b0);
        chk("flush_gone", 64'(out_valid), 64'd0);

        step(1'b1, 32'h3000_2173, 12'h040, 1'b1, 1'b0);
        chk("csr_optype", 64'(out_optype), 64'd6);
        chk("csr_rd", 64'(out_rd), 64'd2);
        chk("csr_rs1v", 64'(out_rs1_valid), 64'd1);
        chk("csr_imm", 64'(out_imm), 64'h300);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1'b1);
            step(1'($urandom_range(0, 3) != 0), rand_instr(),
                 12'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qu_instr_decode.md
Name: qu_instr_decode

Overview:
- Decode stage between fetch and rename/dispatch.
- Accepts raw 32-bit RV32I instruction words plus PC, and produces registered decoded fields: register addresses, sign-extended 32-bit immediate, optype, valid flags, illegal flag.
- Inverse of the instruction encoding helpers in qu_common.
- Valid/ready on both sides, with a 2-entry output skid buffer so input ready is purely registered.

Parameters:
- QU_INSTR_WIDTH, 32, instruction word width (qu_common).
- QU_PC_WIDTH, 12, PC width (qu_common).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  discard all held/in-flight instructions
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decode can accept
- in_instr  in  32  raw instruction (instr_t)
- in_pc  in  12  instruction PC
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_pc  out  12  PC of decoded instr
- out_optype  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 UPPER, 6 SYSTEM, 7 ILLEGAL
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]; 0 unless R-type or shift-immediate
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses; 0 when the matching valid flag is low
- out_rd_valid / out_rs1_valid / out_rs2_valid / out_imm_valid  out  1 each  field used by instr
- out_imm  out  32  sign-extended immediate (0 when imm invalid)
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, in_ready=1, both buffer entries empty, all out_* data=0.
- Accept on in_valid&&in_ready; decoded entry visible on out_* the next cycle (latency 1). Output held stable while out_valid&&!out_ready.
- Skid buffer: main + skid register. in_ready = !skid_full (registered). Accept while main occupied and !out_ready → skid. Pop on out_valid&&out_ready; skid moves to main the same edge. Simultaneous accept+pop with skid full is not possible (in_ready=0). Full-throughput 1 instr/cycle when out_ready=1.
- Decode, by opcode (qu_common values):
  - R_OPCODE → ALU; rd/rs1/rs2 valid; no imm; funct7 must be 0000000, or 0100000 only with funct3 000/101; else illegal.
  - I_OPCODE → ALU; rd/rs1/imm valid; imm = sext(instr[31:20]). funct3 001 requires funct7=0000000; funct3 101 requires funct7 0000000/0100000; shift imm = {27'b0, instr[24:20]}.
  - LOAD_OPCODE → LOAD; funct3 in {000,001,010,100,101} else illegal; I-imm.
  - S_OPCODE → STORE; rs1/rs2/imm; imm = sext({instr[31:25], instr[11:7]}); funct3 ≤ 010 else illegal.
  - B_OPCODE → BRANCH; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); funct3 010/011 illegal.
  - JAL → JUMP; rd+imm; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - JALR → JUMP; rd/rs1/imm; funct3≠000 illegal.
  - LUI/AUIPC → UPPER; rd+imm; imm = {instr[31:12], 12'b0}.
  - SYSTEM_OPCODE: funct3 000 → SYSTEM, ECALL/EBREAK only (imm 0/1, rd=rs1=0), else illegal. CSR funct3 (001,010,011,101,110,111) → SYSTEM, rd valid, imm = {20'b0, csr}; rs1 valid for 001–011; uimm in out_rs1 with rs1_valid=0 for 101–111.
  - FENCE_OPCODE funct3 000/001 → SYSTEM, no regs.
  - Any other opcode, or instr[1:0]≠11 → ILLEGAL.
- Illegal: optype=7, out_illegal=1, all valid flags 0, imm=0. Still passes through the handshake; it is not dropped.
- rd valid but rd=0: rd_valid stays 1 (rename handles x0).
- flush: at the edge both entries are cleared, out_valid=0, in_ready=1. Any same-cycle input is not captured. Flush wins over reset-free accept and pop.
- Reset mid-stream is identical to a flush plus clearing the stats counters.

Optional Feature:
- QU_DECODE_STATS_EN defined: adds outputs stat_decoded (32) and stat_illegal (32). Counters increment on each output handshake (out_valid&&out_ready), with stat_illegal incrementing when that entry is illegal. They wrap at 2^32, clear on reset, and are not cleared by flush.
- Undefined: ports and counters are absent.

Test Plan:
- 0xFFF10093 (addi x1,x2,-1), pc 0x004, out_ready=1 → next cycle out_valid=1, optype 0, rd=1, rs1=2, imm=0xFFFFFFFF, rs2_valid=0.
- 0x00208463 (beq x1,x2,+8) then 0x123452B7 (lui x5,0x12345) back-to-back → BRANCH rs1=1 rs2=2 imm=0x00000008, then UPPER rd=5 imm=0x12345000, with no bubble.
- out_ready=0, push 0x00312223 (sw x3,4(x2)) and 0xFFF10093 → in_ready drops to 0 after the second accept. Release out_ready → STORE (rs1=2, rs2=3, imm=4) first, then the ALU entry, in order.
- 0x00000000 and 0x40001093 (slli with funct7=0100000) → both optype 7, out_illegal=1, imm=0; with QU_DECODE_STATS_EN, stat_illegal=2.
- Skid full, then flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- 0x30002173 (csrrs x2,0x300,x0) → SYSTEM, rd=2, rs1_valid=1, imm=0x00000300.
